roi_capture_ctrl: RTL and testbench

//  Per-frame ROI sequencer on the D5M pixel clock, fed by the binarized stream (RAW2BW oBlack_White/oDVAL).

---
 rtl/roi_capture_ctrl_pkg.sv | 23 ++
 rtl/roi_capture_ctrl_row_run_tracker.sv | 72 +++++++
 rtl/roi_capture_ctrl.sv | 174 +++++++++++++++++
 tb/tb_roi_capture_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_capture_ctrl_pkg.sv
// Shared definitions for the ROI capture controller: state encoding,
// default geometry and the shift amounts behind the band thresholds.
package roi_capture_ctrl_pkg;

  localparam int unsigned DEF_COL_W      = 12;
  localparam int unsigned DEF_ROW_W      = 12;
  localparam int unsigned DEF_GAP_CYCLES = 5;
  localparam int unsigned DEF_MIN_ROWS   = 4;

  // enter = prev/2 + prev/4, exit = prev + prev/2
  localparam int unsigned ENTER_SHIFT_A = 1;
  localparam int unsigned ENTER_SHIFT_B = 2;
  localparam int unsigned EXIT_SHIFT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SEEK  = 3'd2,
    ST_INROI = 3'd3,
    ST_DONE  = 3'd4
  } roi_state_e;

endpackage

// File: rtl/roi_capture_ctrl_row_run_tracker.sv
// Per-row pixel bookkeeping: column count, white-run length and row maximum,
// end-of-row detection from the horizontal gap, and a black-pixel strobe.
module roi_capture_ctrl_row_run_tracker
  import roi_capture_ctrl_pkg::*;
#(
  parameter int unsigned COL_W      = DEF_COL_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fval_i,
  input  logic             dval_i,
  input  logic             pix_i,
  output logic             row_end_c,
  output logic             blk_c,
  output logic [COL_W-1:0] blk_col_c,
  output logic [COL_W-1:0] row_max_o
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [COL_W-1:0] SAT = '1;

  logic [COL_W-1:0] col_q, col_d, run_q, run_d, max_q, max_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             active_q, active_d;

  // The row end is seen on the idle cycle that completes the gap.
  assign row_end_c = active_q && !dval_i && (gap_q == GAP_W'(GAP_CYCLES - 1));
  assign blk_c     = fval_i && dval_i && !pix_i;
  assign blk_col_c = col_q;
  assign row_max_o = max_q;

  always_comb begin
    col_d    = col_q;
    run_d    = run_q;
    max_d    = max_q;
    gap_d    = gap_q;
    active_d = active_q;
    if (!fval_i || row_end_c) begin
      col_d    = '0;
      run_d    = '0;
      max_d    = '0;
      gap_d    = '0;
      active_d = 1'b0;
    end else if (dval_i) begin
      col_d    = (col_q == SAT) ? col_q : col_q + COL_W'(1);
      run_d    = !pix_i ? '0 : ((run_q == SAT) ? run_q : run_q + COL_W'(1));
      max_d    = (run_d > max_q) ? run_d : max_q;
      gap_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q    <= '0;
      run_q    <= '0;
      max_q    <= '0;
      gap_q    <= '0;
      active_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      run_q    <= run_d;
      max_q    <= max_d;
      gap_q    <= gap_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/roi_capture_ctrl.sv
// Per-frame ROI sequencer: finds a dark band from the drop in per-row white
// run length, gates recording over it and reports its bounding box.
module roi_capture_ctrl
  import roi_capture_ctrl_pkg::*;
#(
  parameter int unsigned COL_W      = DEF_COL_W,
  parameter int unsigned ROW_W      = DEF_ROW_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned MIN_ROWS   = DEF_MIN_ROWS
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic             iPIX,
  input  logic             iSTART,
  input  logic             iABORT,
  output logic             oRECORD,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oFOUND,
  output logic [ROW_W-1:0] oTOP,
  output logic [ROW_W-1:0] oBOTTOM,
  output logic [COL_W-1:0] oLEFT,
  output logic [COL_W-1:0] oRIGHT,
  output logic [2:0]       oSTATE
);

  localparam int unsigned THR_W = COL_W + 1;

  roi_state_e       state_q, state_d;
  logic             fval_q;
  logic [ROW_W-1:0] row_q, row_d, top_q, top_d, bot_q, bot_d, rows_done;
  logic [COL_W-1:0] prev_q, prev_d, left_q, left_d, right_q, right_d;
  logic             found_q, found_d, rec_q, busy_q, done_q;
  logic             row_end, blk;
  logic [COL_W-1:0] blk_col, row_max;
  logic [THR_W-1:0] enter_thr, exit_thr, max_ext;
  logic             fval_rise, fval_fall;

  roi_capture_ctrl_row_run_tracker #(
    .COL_W      (COL_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_tracker (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .fval_i    (iFVAL),
    .dval_i    (iDVAL),
    .pix_i     (iPIX),
    .row_end_c (row_end),
    .blk_c     (blk),
    .blk_col_c (blk_col),
    .row_max_o (row_max)
  );

  assign fval_rise = iFVAL && !fval_q;
  assign fval_fall = !iFVAL && fval_q;
  assign max_ext   = THR_W'(row_max);
  assign enter_thr = THR_W'(prev_q >> ENTER_SHIFT_A) + THR_W'(prev_q >> ENTER_SHIFT_B);
  assign exit_thr  = THR_W'(prev_q) + THR_W'(prev_q >> EXIT_SHIFT);
  // Completed rows including one that ends on this very cycle.
  assign rows_done = row_end ? row_q + ROW_W'(1) : row_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    prev_d  = prev_q;
    top_d   = top_q;
    bot_d   = bot_q;
    left_d  = left_q;
    right_d = right_q;
    found_d = found_q;

    if (!iFVAL) begin
      row_d  = '0;
      prev_d = '0;
    end else if (row_end) begin
      row_d  = row_q + ROW_W'(1);
      prev_d = row_max;
    end

    if (iABORT) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (iSTART) begin
            state_d = ST_ARMED;
            found_d = 1'b0;
          end
        end
        ST_ARMED: if (fval_rise) state_d = ST_SEEK;
        ST_SEEK: begin
          if (row_end && (row_q != '0) && (max_ext < enter_thr)) begin
            state_d = ST_INROI;
            top_d   = row_q;
            left_d  = '1;
            right_d = '0;
          end
        end
        ST_INROI: begin
          if (blk) begin
            if (blk_col < left_q)  left_d  = blk_col;
            if (blk_col > right_q) right_d = blk_col;
          end
          if (row_end && (max_ext > exit_thr)) begin
            if ((row_q - top_q) >= ROW_W'(MIN_ROWS)) begin
              state_d = ST_DONE;
              found_d = 1'b1;
              bot_d   = row_q;
            end else begin
              state_d = ST_SEEK;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      // Frame end is resolved after any row end landing on the same cycle.
      if (fval_fall && ((state_q == ST_SEEK) || (state_q == ST_INROI))) begin
        if (state_d == ST_SEEK) begin
          state_d = ST_DONE;
          found_d = 1'b0;
        end else if (state_d == ST_INROI) begin
          state_d = ST_DONE;
          found_d = (rows_done - top_d) >= ROW_W'(MIN_ROWS);
          bot_d   = rows_done - ROW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      fval_q  <= 1'b0;
      row_q   <= '0;
      prev_q  <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      found_q <= 1'b0;
      rec_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      row_q   <= row_d;
      prev_q  <= prev_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      left_q  <= left_d;
      right_q <= right_d;
      found_q <= found_d;
      rec_q   <= (state_d == ST_INROI);
      busy_q  <= (state_d == ST_ARMED) || (state_d == ST_SEEK) || (state_d == ST_INROI);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign oRECORD = rec_q;
  assign oBUSY   = busy_q;
  assign oDONE   = done_q;
  assign oFOUND  = found_q;
  assign oTOP    = top_q;
  assign oBOTTOM = bot_q;
  assign oLEFT   = left_q;
  assign oRIGHT  = right_q;
  assign oSTATE  = state_q;

endmodule

// File: tb/tb_roi_capture_ctrl.sv
// Bench for roi_capture_ctrl: directed frames plus randomized frames, every
// cycle compared against a frame/row-level behavioural model.
module tb_roi_capture_ctrl;

  localparam int GAP = 5;
  localparam int MINR = 4;
  localparam int SAT = 4095;
  localparam int S_IDLE = 0, S_ARMED = 1, S_SEEK = 2, S_INROI = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fval = 1'b0, dval = 1'b0, pix = 1'b0, start = 1'b0, abort = 1'b0;
  logic        oRECORD, oBUSY, oDONE, oFOUND;
  logic [11:0] oTOP, oBOTTOM, oLEFT, oRIGHT;
  logic [2:0]  oSTATE;

  roi_capture_ctrl dut (
    .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval), .iPIX(pix),
    .iSTART(start), .iABORT(abort),
    .oRECORD(oRECORD), .oBUSY(oBUSY), .oDONE(oDONE), .oFOUND(oFOUND),
    .oTOP(oTOP), .oBOTTOM(oBOTTOM), .oLEFT(oLEFT), .oRIGHT(oRIGHT), .oSTATE(oSTATE)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_done = 0;
  int cyc = 0, start_at = -1, start_at2 = -1, abort_at = -1, rst_at = -1;
  bit jitter = 0;

  // model: row statistics and search outcome
  int m_st, m_col, m_run, m_max, m_gap, m_row, m_prev, m_top, m_bot, m_left, m_right;
  bit m_active, m_fvp, m_found;

  int rw[$], rlo[$], rhi[$], rnz[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_col = 0; m_run = 0; m_max = 0; m_gap = 0; m_row = 0; m_prev = 0;
    m_top = 0; m_bot = 0; m_left = 0; m_right = 0; m_active = 0; m_fvp = 0; m_found = 0;
  endtask

  // Search decisions for a completed row, then for a frame that ends.
  task automatic model_step(input bit fv, input bit dv, input bit px, input bit st, input bit ab);
    bit rend, rise, fall;
    int nxt, completed;
    rend = m_active && !dv && (m_gap == GAP - 1);
    rise = fv && !m_fvp;
    fall = !fv && m_fvp;
    nxt = m_st;
    if (ab) nxt = S_IDLE;
    else begin
      if (m_st == S_IDLE && st) begin nxt = S_ARMED; m_found = 0; end
      if (m_st == S_ARMED && rise) nxt = S_SEEK;
      if (m_st == S_DONE) nxt = S_IDLE;
      if (m_st == S_INROI && fv && dv && !px) begin
        if (m_col < m_left) m_left = m_col;
        if (m_col > m_right) m_right = m_col;
      end
      if (rend && m_st == S_SEEK && m_row > 0 && m_max < m_prev / 2 + m_prev / 4) begin
        nxt = S_INROI; m_top = m_row; m_left = SAT; m_right = 0;
      end
      if (rend && m_st == S_INROI && m_max > m_prev + m_prev / 2) begin
        if (m_row - m_top >= MINR) begin nxt = S_DONE; m_found = 1; m_bot = m_row; end
        else nxt = S_SEEK;
      end
      if (fall && (m_st == S_SEEK || m_st == S_INROI)) begin
        completed = m_row + (rend ? 1 : 0);
        if (nxt == S_SEEK) begin nxt = S_DONE; m_found = 0; end
        else if (nxt == S_INROI) begin
          nxt = S_DONE; m_found = (completed - m_top) >= MINR; m_bot = completed - 1;
        end
      end
    end
    if (!fv) begin
      m_col = 0; m_run = 0; m_max = 0; m_gap = 0; m_active = 0; m_row = 0; m_prev = 0;
    end else if (rend) begin
      m_prev = m_max; m_row++;
      m_col = 0; m_run = 0; m_max = 0; m_gap = 0; m_active = 0;
    end else if (dv) begin
      if (m_col < SAT) m_col++;
      m_run = px ? ((m_run < SAT) ? m_run + 1 : SAT) : 0;
      if (m_run > m_max) m_max = m_run;
      m_gap = 0; m_active = 1;
    end else if (m_active) m_gap++;
    m_st = nxt;
    m_fvp = fv;
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, "_state"}, int'(oSTATE), m_st);
    chk({ctx, "_record"}, int'(oRECORD), int'(m_st == S_INROI));
    chk({ctx, "_busy"}, int'(oBUSY), int'(m_st >= S_ARMED && m_st <= S_INROI));
    chk({ctx, "_done"}, int'(oDONE), int'(m_st == S_DONE));
    chk({ctx, "_found"}, int'(oFOUND), int'(m_found));
    chk({ctx, "_top"}, int'(oTOP), m_top);
    chk({ctx, "_bottom"}, int'(oBOTTOM), m_bot);
    chk({ctx, "_left"}, int'(oLEFT), m_left);
    chk({ctx, "_right"}, int'(oRIGHT), m_right);
  endtask

  task automatic tick(input bit fv, input bit dv, input bit px);
    fval = fv; dval = dv; pix = px;
    start = (cyc == start_at) || (cyc == start_at2);
    abort = (cyc == abort_at);
    if (cyc == rst_at) begin
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_all("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      model_step(fv, dv, px, start, abort);
      @(posedge clk);
      #1;
    end
    cyc++;
    if (oDONE) n_done++;
    compare_all("cyc");
  endtask

  task automatic send_row(input int w, input int lo, input int hi, input int nz);
    for (int c = 0; c < w; c++) begin
      bit p;
      p = (c >= lo) && (c < hi);
      if (nz > 0 && $urandom_range(99) < nz) p = !p;
      tick(1, 1, p);
      if (jitter && $urandom_range(9) == 0 && c < w - 1) repeat ($urandom_range(3, 1)) tick(1, 0, 0);
    end
  endtask

  task automatic add_row(input int w, input int lo, input int hi, input int nz);
    rw.push_back(w); rlo.push_back(lo); rhi.push_back(hi); rnz.push_back(nz);
  endtask

  task automatic run_frame(input bit arm, input int tail);
    n_done = 0;
    if (arm) start_at = cyc + 1;
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 0);
    for (int r = 0; r < rw.size(); r++) begin
      send_row(rw[r], rlo[r], rhi[r], rnz[r]);
      if (r < rw.size() - 1) repeat (GAP + (jitter ? $urandom_range(3) : 1)) tick(1, 0, 0);
      else repeat (tail) tick(1, 0, 0);
    end
    repeat (3) tick(0, 0, 0);
    rw.delete(); rlo.delete(); rhi.delete(); rnz.delete();
    start_at = -1; start_at2 = -1; abort_at = -1; rst_at = -1;
  endtask

  task automatic expect_box(input string tag, input int found, input int top, input int bot,
                            input int left, input int right, input int dones);
    chk({tag, "_found"}, int'(oFOUND), found);
    chk({tag, "_top"}, int'(oTOP), top);
    chk({tag, "_bottom"}, int'(oBOTTOM), bot);
    chk({tag, "_left"}, int'(oLEFT), left);
    chk({tag, "_right"}, int'(oRIGHT), right);
    chk({tag, "_dones"}, n_done, dones);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    compare_all("reset");

    // white x3 then black x5: band runs to the end of the frame
    repeat (3) add_row(16, 0, 16, 0);
    repeat (5) add_row(16, 0, 0, 0);
    run_frame(1, 8);
    expect_box("t1", 1, 3, 7, 0, 15, 1);

    // white, black x5, white: band closed by the bright row
    add_row(16, 0, 16, 0);
    repeat (5) add_row(16, 0, 0, 0);
    add_row(16, 0, 16, 0);
    run_frame(1, 8);
    expect_box("t2", 1, 1, 6, 0, 15, 1);

    // short band discarded
    add_row(16, 0, 16, 0);
    repeat (2) add_row(16, 0, 0, 0);
    repeat (2) add_row(16, 0, 16, 0);
    run_frame(1, 8);
    chk("t3_found", int'(oFOUND), 0);
    chk("t3_dones", n_done, 1);

    // abort inside the band, stray start during the search
    add_row(16, 0, 16, 0);
    repeat (6) add_row(16, 0, 0, 0);
    add_row(16, 0, 16, 0);
    start_at2 = cyc + 9;
    abort_at = cyc + 70;
    run_frame(1, 8);
    chk("t4_dones", n_done, 0);
    chk("t4_state", int'(oSTATE), S_IDLE);
    chk("t4_record", int'(oRECORD), 0);

    // entry row ends on the same cycle as the frame
    repeat (2) add_row(16, 0, 16, 0);
    add_row(16, 0, 0, 0);
    run_frame(1, GAP - 1);
    expect_box("t5", 0, 2, 2, SAT, 0, 1);

    // reset mid-frame, then a frame without re-arming stays idle
    repeat (3) add_row(16, 0, 16, 0);
    repeat (5) add_row(16, 0, 0, 0);
    rst_at = cyc + 60;
    run_frame(1, 8);
    chk("t6_dones", n_done, 0);
    repeat (3) add_row(16, 0, 16, 0);
    repeat (5) add_row(16, 0, 0, 0);
    run_frame(0, 8);
    chk("t6_noarm_dones", n_done, 0);
    chk("t6_noarm_state", int'(oSTATE), S_IDLE);

    // saturation of run and column on rows wider than the counters
    add_row(4100, 0, 4100, 0);
    add_row(3070, 0, 3069, 0);
    add_row(4100, 0, 4098, 0);
    add_row(16, 0, 0, 0);
    run_frame(1, 8);
    expect_box("t7", 0, 1, 3, 0, SAT, 1);

    // randomized frames
    jitter = 1;
    for (int f = 0; f < 40; f++) begin
      int nrows, bs, bl, tail;
      bit arm;
      nrows = $urandom_range(10, 2);
      bs = $urandom_range(nrows - 1);
      bl = $urandom_range(6, 1);
      for (int r = 0; r < nrows; r++) begin
        int w;
        w = $urandom_range(24, 6);
        if (r >= bs && r < bs + bl) add_row(w, $urandom_range(w / 2), $urandom_range(w / 2), $urandom_range(8));
        else add_row(w, $urandom_range(3), w, $urandom_range(6));
      end
      arm = ($urandom_range(9) < 8);
      tail = $urandom_range(9);
      if ($urandom_range(4) == 0) abort_at = cyc + $urandom_range(150, 5);
      if ($urandom_range(2) == 0) start_at2 = cyc + $urandom_range(100, 5);
      run_frame(arm, tail);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
